mxint_dot_product_arbiter: RTL

Round-robin arbiter that time-shares one MXINT block dot-product unit between `NUM_REQ` requesters. Each requester supplies a (data block, weight block) pair; the arbiter forwards one pair per grant and records the requester index in an in-order tag FIFO. It routes each returning result back to the requester that issued it. It sits between several linear-layer tile controllers and a single shared `mxint_dot_product` instance.

---
 rtl/mxint_dot_product_arbiter.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mxint_dot_product_arbiter.sv
// Round-robin arbiter time-sharing one MXINT block dot-product unit; zero-latency issue and return.
// Issue stalls while MAX_OUTSTANDING results are in flight; results wait on the owning requester's res_ready.

module mxint_dot_product_arbiter_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({push && !full, pop && !empty})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
endmodule

module mxint_dot_product_arbiter #(
    parameter int NUM_REQ                = 4,
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 8,
    parameter int WEIGHT_PRECISION_0     = 8,
    parameter int WEIGHT_PRECISION_1     = 8,
    parameter int BLOCK_SIZE             = 6,
    parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(BLOCK_SIZE),
    parameter int DATA_OUT_0_PRECISION_1 = ((DATA_IN_0_PRECISION_1 > WEIGHT_PRECISION_1) ?
                                            DATA_IN_0_PRECISION_1 : WEIGHT_PRECISION_1) + 1,
    parameter int MAX_OUTSTANDING        = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_REQ*BLOCK_SIZE*DATA_IN_0_PRECISION_0-1:0]   req_mdata,
    input  logic [NUM_REQ*DATA_IN_0_PRECISION_1-1:0]              req_edata,
    input  logic [NUM_REQ*BLOCK_SIZE*WEIGHT_PRECISION_0-1:0]      req_mweight,
    input  logic [NUM_REQ*WEIGHT_PRECISION_1-1:0]                 req_eweight,
    input  logic [NUM_REQ-1:0]                                    req_valid,
    output logic [NUM_REQ-1:0]                                    req_ready,
    output logic [BLOCK_SIZE*DATA_IN_0_PRECISION_0-1:0]           dp_mdata,
    output logic [DATA_IN_0_PRECISION_1-1:0]                      dp_edata,
    output logic                                                  dp_data_valid,
    input  logic                                                  dp_data_ready,
    output logic [BLOCK_SIZE*WEIGHT_PRECISION_0-1:0]              dp_mweight,
    output logic [WEIGHT_PRECISION_1-1:0]                         dp_eweight,
    output logic                                                  dp_weight_valid,
    input  logic                                                  dp_weight_ready,
    input  logic [DATA_OUT_0_PRECISION_0-1:0]                     dp_mout,
    input  logic [DATA_OUT_0_PRECISION_1-1:0]                     dp_eout,
    input  logic                                                  dp_out_valid,
    output logic                                                  dp_out_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0]                     res_mdata,
    output logic [DATA_OUT_0_PRECISION_1-1:0]                     res_edata,
    output logic [NUM_REQ-1:0]                                    res_valid,
    input  logic [NUM_REQ-1:0]                                    res_ready,
    output logic                                                  err_orphan
);
    localparam int IW  = $clog2(NUM_REQ);
    localparam int DMW = BLOCK_SIZE * DATA_IN_0_PRECISION_0;
    localparam int WMW = BLOCK_SIZE * WEIGHT_PRECISION_0;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            data_sent_q, data_sent_d;
    logic            wt_sent_q, wt_sent_d;

    logic            scan_found;
    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   cur_gnt;
    logic            active;
    logic            data_hs;
    logic            wt_hs;
    logic            pair_done;

    logic            tag_push;
    logic            tag_pop;
    logic [IW-1:0]   tag_head;
    logic            tag_full;
    logic            tag_empty;
    logic            orphan;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin : scan
        logic [IW:0] sum;
        scan_found = 1'b0;
        scan_idx   = '0;
        sum        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            if (!scan_found && req_valid[sum[IW-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        ptr_d           = ptr_q;
        data_sent_d     = data_sent_q;
        wt_sent_d       = wt_sent_q;
        cur_gnt         = gnt_q;
        active          = 1'b0;
        dp_data_valid   = 1'b0;
        dp_weight_valid = 1'b0;
        data_hs         = 1'b0;
        wt_hs           = 1'b0;
        pair_done       = 1'b0;
        req_ready       = '0;
        tag_push        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan_found && !tag_full) begin
                    active  = 1'b1;
                    cur_gnt = scan_idx;
                end
            end
            ST_LOCKED: active = 1'b1;
            default: active = 1'b0;
        endcase

        if (active) begin
            dp_data_valid   = !data_sent_q;
            dp_weight_valid = !wt_sent_q;
            data_hs         = dp_data_valid && dp_data_ready;
            wt_hs           = dp_weight_valid && dp_weight_ready;
            pair_done       = (data_sent_q || data_hs) && (wt_sent_q || wt_hs);
            if (pair_done) begin
                req_ready[cur_gnt] = 1'b1;
                tag_push           = 1'b1;
                state_d            = ST_IDLE;
                data_sent_d        = 1'b0;
                wt_sent_d          = 1'b0;
                ptr_d              = (cur_gnt == IW'(NUM_REQ - 1)) ? '0 : cur_gnt + IW'(1);
            end else begin
                // Grant is held until both halves of the pair have been taken.
                state_d     = ST_LOCKED;
                gnt_d       = cur_gnt;
                data_sent_d = data_sent_q || data_hs;
                wt_sent_d   = wt_sent_q || wt_hs;
            end
        end
    end

    assign dp_mdata   = req_mdata[int'(cur_gnt) * DMW +: DMW];
    assign dp_edata   = req_edata[int'(cur_gnt) * DATA_IN_0_PRECISION_1 +: DATA_IN_0_PRECISION_1];
    assign dp_mweight = req_mweight[int'(cur_gnt) * WMW +: WMW];
    assign dp_eweight = req_eweight[int'(cur_gnt) * WEIGHT_PRECISION_1 +: WEIGHT_PRECISION_1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            data_sent_q <= 1'b0;
            wt_sent_q   <= 1'b0;
            err_orphan  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            data_sent_q <= data_sent_d;
            wt_sent_q   <= wt_sent_d;
            err_orphan  <= err_orphan | orphan;
        end
    end

    mxint_dot_product_arbiter_tag_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_push),
        .push_data (cur_gnt),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // A result with no tag outstanding is drained so the shared unit cannot wedge.
    always_comb begin
        res_valid    = '0;
        dp_out_ready = 1'b0;
        tag_pop      = 1'b0;
        orphan       = 1'b0;
        if (tag_empty) begin
            dp_out_ready = dp_out_valid;
            orphan       = dp_out_valid;
        end else begin
            res_valid[tag_head] = dp_out_valid;
            dp_out_ready        = res_ready[tag_head];
            tag_pop             = dp_out_valid && res_ready[tag_head];
        end
    end

    assign res_mdata = dp_mout;
    assign res_edata = dp_eout;
endmodule
